wrap_select: RTL and testbench
==============================

Name: wrap_select

Overview:
- Per-core wrap scheduler sitting directly upstream of the fetch stage.
- Each cycle it picks one eligible wrap round-robin and presents it to fetch as a registered one-hot select plus index. Fetch advances that wrap's PC on acceptance.
- Eligibility tracks three things per wrap: launch enable, instruction-cache miss sleep, and instruction-queue credits.

Parameters:
- NUM_WRAPS_PER_CORE, 4, number of hardware wraps; must be >= 2.
- IQ_DEPTH, 4, per-wrap instruction queue depth downstream; initial credit count.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- wrap_enable  in  NUM_WRAPS_PER_CORE  wrap launched/running (level)
- icache_miss_valid  in  1  fetch reports a miss for a wrap
- icache_miss_wrap_id  in  $clog2(NUM_WRAPS_PER_CORE)  wrap that missed
- icache_fill_valid  in  1  miss serviced; wake a wrap
- icache_fill_wrap_id  in  $clog2(NUM_WRAPS_PER_CORE)  wrap to wake
- iq_dequeue  in  NUM_WRAPS_PER_CORE  one bit per wrap: one queue entry freed this cycle
- ifetch_ready  in  1  fetch accepts the current selection
- select_valid  out  1  selection valid
- selected_wrap_oh  out  NUM_WRAPS_PER_CORE  one-hot selected wrap
- selected_wrap_id  out  $clog2(NUM_WRAPS_PER_CORE)  index of selected wrap

Behaviour:
- Reset is asynchronous on reset_n low. Reset values:
  - select_valid=0, selected_wrap_oh=0, selected_wrap_id=0.
  - All sleep bits=0.
  - All credits=IQ_DEPTH.
  - Round-robin pointer set so wrap 0 has highest priority.
- Credit counter width is $clog2(IQ_DEPTH+1).
- Eligibility: eligible[w] = wrap_enable[w] & !sleep[w] & credit[w]!=0. The sleep term uses registered state; miss/fill in the current cycle do not affect the current cycle's pick.
- Load condition: load = !select_valid | ifetch_ready.
  - When load=1, the arbiter picks the first eligible wrap at or after (last_grant+1) mod NUM_WRAPS_PER_CORE.
  - The pick is registered into the outputs, so the output appears one cycle later.
  - If no wrap is eligible, select_valid goes to 0 at the next edge.
- Hold: when select_valid=1 and ifetch_ready=0, all outputs are held unchanged and no new pick is made (valid/ready stall).
- Pointer: last_grant updates only when a pick is loaded.
- Credits are decremented for the picked wrap at the load edge.
  - iq_dequeue[w] increments credit[w].
  - A decrement and an increment on the same wrap in the same cycle net to zero.
  - A dequeue while credit==IQ_DEPTH is illegal (bench assertion); the RTL saturates.
- Sleep:
  - icache_miss_valid sets sleep[miss_id] at the next edge.
  - icache_fill_valid clears sleep[fill_id].
  - Miss and fill on the same wrap in the same cycle: miss wins (sleep set).
- Cancel: if a held selection (select_valid=1, ifetch_ready=0) is for a wrap that receives a miss, or whose wrap_enable deasserts, the selection is cancelled:
  - select_valid=0 at the next edge;
  - that wrap's credit is incremented back by 1;
  - last_grant is unchanged by the cancel.
- Disable: a wrap with wrap_enable=0 is never picked. Its credits and sleep bit are retained.
- Invariants:
  - selected_wrap_oh is exactly one-hot when select_valid=1, and all zeros when select_valid=0.
  - selected_wrap_id always matches selected_wrap_oh.
- Reset mid-operation clears all state immediately; no credit reconciliation is done.

Test Plan:
- Reset, all 4 wraps enabled, ifetch_ready=1, no dequeues -> grants 0,1,2,3,0,... on consecutive cycles starting the cycle after the first edge. Each wrap gets 4 grants, then select_valid=0.
- Only wrap 2 enabled with IQ_DEPTH=4, ifetch_ready=1 -> 4 grants of wrap 2 (oh=0100), then valid=0. One iq_dequeue[2] pulse -> exactly one more grant.
- ifetch_ready=0 for 3 cycles while wrap 1 is selected -> outputs held at oh=0010, id=1. Credit[1] decremented only once; the next grant after ready rises is wrap 2.
- icache_miss on wrap 0 -> wrap 0 skipped in rotation. A fill for wrap 0 two cycles later -> wrap 0 granted again in its next turn. Miss and fill on wrap 3 in the same cycle -> wrap 3 sleeps.
- Held selection of wrap 1 (ready=0), then miss for wrap 1 -> select_valid=0 next cycle, credit[1] restored to its pre-grant value, next pick resumes at wrap 2.
- Same-cycle grant and iq_dequeue on wrap 0 with credit=1 -> credit stays 1. reset_n asserted mid-stream -> outputs 0 immediately and all credits=4.

Source files
------------

// File: rtl/wrap_select.sv
// Round-robin wrap scheduler feeding fetch: picks one eligible wrap per load and
// tracks per-wrap instruction-cache sleep and instruction-queue credits.
module wrap_select #(
   parameter int NUM_WRAPS_PER_CORE = 4,
   parameter int IQ_DEPTH           = 4
) (
   input  logic                                  clk,
   input  logic                                  reset_n,
   input  logic [NUM_WRAPS_PER_CORE-1:0]         wrap_enable,
   input  logic                                  icache_miss_valid,
   input  logic [$clog2(NUM_WRAPS_PER_CORE)-1:0] icache_miss_wrap_id,
   input  logic                                  icache_fill_valid,
   input  logic [$clog2(NUM_WRAPS_PER_CORE)-1:0] icache_fill_wrap_id,
   input  logic [NUM_WRAPS_PER_CORE-1:0]         iq_dequeue,
   input  logic                                  ifetch_ready,
   output logic                                  select_valid,
   output logic [NUM_WRAPS_PER_CORE-1:0]         selected_wrap_oh,
   output logic [$clog2(NUM_WRAPS_PER_CORE)-1:0] selected_wrap_id
);

   localparam int N    = NUM_WRAPS_PER_CORE;
   localparam int ID_W = $clog2(N);
   localparam int CW   = $clog2(IQ_DEPTH + 1);
   localparam int SW   = CW + 2;
   localparam logic [CW-1:0]   CREDIT_MAX = CW'(IQ_DEPTH);
   localparam logic [ID_W-1:0] LAST_ID    = ID_W'(N - 1);

   logic [N-1:0]          sleep_reg, sleep_next;
   logic [N-1:0][CW-1:0]  credit_reg, credit_next;
   logic [ID_W-1:0]       last_grant_reg;
   logic                  valid_reg;
   logic [N-1:0]          oh_reg;
   logic [ID_W-1:0]       id_reg;

   logic [N-1:0]          eligible;
   logic [N-1:0]          pick_oh;
   logic                  pick_found;
   logic [ID_W-1:0]       pick_id;
   logic                  load;
   logic                  cancel;

   assign load   = !valid_reg || ifetch_ready;
   // A stalled selection is withdrawn if its wrap misses or is disabled.
   assign cancel = valid_reg && !ifetch_ready &&
                   ((icache_miss_valid && (icache_miss_wrap_id == id_reg)) || !wrap_enable[id_reg]);

   always_comb begin
      logic [ID_W-1:0] cand;
      pick_found = 1'b0;
      pick_id    = '0;
      cand       = '0;
      for (int k = 1; k <= N; k++) begin
         cand = ID_W'((int'(last_grant_reg) + k) % N);
         if (!pick_found && eligible[cand]) begin
            pick_found = 1'b1;
            pick_id    = cand;
         end
      end
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_wrap
      logic          take;
      logic          give_back;
      logic [SW-1:0] credit_sum;

      assign eligible[gi] = wrap_enable[gi] && !sleep_reg[gi] && (credit_reg[gi] != '0);
      assign pick_oh[gi]  = pick_found && (pick_id == ID_W'(gi));

      assign take       = load && pick_oh[gi];
      assign give_back  = cancel && (id_reg == ID_W'(gi));
      // Never underflows: a wrap is only taken while its credit is non-zero.
      assign credit_sum = SW'(credit_reg[gi]) + SW'(iq_dequeue[gi]) + SW'(give_back) - SW'(take);
      assign credit_next[gi] = (credit_sum > SW'(IQ_DEPTH)) ? CREDIT_MAX : credit_sum[CW-1:0];

      // Miss takes priority over a same-cycle fill for the same wrap.
      assign sleep_next[gi] = (icache_miss_valid && (icache_miss_wrap_id == ID_W'(gi))) ? 1'b1 :
                              (icache_fill_valid && (icache_fill_wrap_id == ID_W'(gi))) ? 1'b0 :
                              sleep_reg[gi];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sleep_reg  <= '0;
         credit_reg <= {N{CREDIT_MAX}};
      end else begin
         sleep_reg  <= sleep_next;
         credit_reg <= credit_next;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_reg      <= 1'b0;
         oh_reg         <= '0;
         id_reg         <= '0;
         last_grant_reg <= LAST_ID;
      end else if (load) begin
         valid_reg <= pick_found;
         oh_reg    <= pick_oh;
         id_reg    <= pick_id;
         if (pick_found) begin
            last_grant_reg <= pick_id;
         end
      end else if (cancel) begin
         valid_reg <= 1'b0;
         oh_reg    <= '0;
         id_reg    <= '0;
      end
   end

   assign select_valid     = valid_reg;
   assign selected_wrap_oh = oh_reg;
   assign selected_wrap_id = id_reg;

endmodule

// File: tb/tb_wrap_select.sv
// Self-checking bench for wrap_select: directed scenarios plus randomized traffic
// compared against a behavioural scheduler model.
`timescale 1ns/1ps
module tb_wrap_select;

   localparam int N     = 4;
   localparam int DEPTH = 4;
   localparam int ID_W  = $clog2(N);
   localparam int BW    = 1 + N + ID_W;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic [N-1:0]    wrap_enable = '0;
   logic            icache_miss_valid = 1'b0;
   logic [ID_W-1:0] icache_miss_wrap_id = '0;
   logic            icache_fill_valid = 1'b0;
   logic [ID_W-1:0] icache_fill_wrap_id = '0;
   logic [N-1:0]    iq_dequeue = '0;
   logic            ifetch_ready = 1'b1;
   logic            select_valid;
   logic [N-1:0]    selected_wrap_oh;
   logic [ID_W-1:0] selected_wrap_id;

   always #5 clk = ~clk;

   wrap_select #(.NUM_WRAPS_PER_CORE(N), .IQ_DEPTH(DEPTH)) dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .wrap_enable         (wrap_enable),
      .icache_miss_valid   (icache_miss_valid),
      .icache_miss_wrap_id (icache_miss_wrap_id),
      .icache_fill_valid   (icache_fill_valid),
      .icache_fill_wrap_id (icache_fill_wrap_id),
      .iq_dequeue          (iq_dequeue),
      .ifetch_ready        (ifetch_ready),
      .select_valid        (select_valid),
      .selected_wrap_oh    (selected_wrap_oh),
      .selected_wrap_id    (selected_wrap_id)
   );

   // Observed bus, packed as {valid, one-hot, id}.
   logic [BW-1:0] got;
   assign got = {select_valid, selected_wrap_oh, selected_wrap_id};

   int checks = 0;
   int passes = 0;

   // Behavioural model of the scheduler state.
   int m_credit [N];
   bit m_sleep  [N];
   int m_last;
   bit m_valid;
   int m_id;

   function automatic logic [BW-1:0] pack(input bit v, input int id);
      logic [N-1:0]    oh;
      logic [ID_W-1:0] idx;
      oh  = v ? (N'(1) << id) : '0;
      idx = v ? ID_W'(id) : '0;
      return {v, oh, idx};
   endfunction

   function automatic void model_reset();
      for (int w = 0; w < N; w++) begin
         m_credit[w] = DEPTH;
         m_sleep[w]  = 1'b0;
      end
      m_last  = N - 1;
      m_valid = 1'b0;
      m_id    = 0;
   endfunction

   // Advance the model by one clock edge using the inputs currently driven.
   function automatic void model_step();
      bit load, cancel;
      int pick;
      int c;
      load   = !m_valid || ifetch_ready;
      cancel = m_valid && !ifetch_ready &&
               ((icache_miss_valid && int'(icache_miss_wrap_id) == m_id) || !wrap_enable[m_id]);
      pick = -1;
      if (load) begin
         for (int k = 1; k <= N; k++) begin
            int w = (m_last + k) % N;
            if (pick < 0 && wrap_enable[w] && !m_sleep[w] && m_credit[w] > 0) pick = w;
         end
      end
      for (int w = 0; w < N; w++) begin
         assert (!(iq_dequeue[w] && m_credit[w] >= DEPTH)) else $error("illegal dequeue on wrap %0d", w);
         c = m_credit[w];
         if (iq_dequeue[w]) c++;
         if (cancel && w == m_id) c++;
         if (pick == w) c--;
         if (c > DEPTH) c = DEPTH;
         m_credit[w] = c;
         if (icache_miss_valid && int'(icache_miss_wrap_id) == w) m_sleep[w] = 1'b1;
         else if (icache_fill_valid && int'(icache_fill_wrap_id) == w) m_sleep[w] = 1'b0;
      end
      if (load) begin
         m_valid = (pick >= 0);
         m_id    = (pick >= 0) ? pick : 0;
         if (pick >= 0) m_last = pick;
      end else if (cancel) begin
         m_valid = 1'b0;
         m_id    = 0;
      end
   endfunction

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      icache_miss_valid = 1'b0;
      icache_fill_valid = 1'b0;
      iq_dequeue        = '0;
   endtask

   task automatic apply_reset();
      reset_n      = 1'b0;
      wrap_enable  = '0;
      ifetch_ready = 1'b1;
      icache_miss_valid = 1'b0;
      icache_fill_valid = 1'b0;
      iq_dequeue   = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #1;
      checks++;
      if (got !== pack(0, 0)) $display("FAIL reset_outputs: got %b want %b", got, pack(0, 0));
      else passes++;
      apply_reset();
      cycle();
      checks++;
      if (got !== pack(0, 0)) $display("FAIL reset_idle_no_enable: got %b want %b", got, pack(0, 0));
      else passes++;
   endtask

   task automatic test_round_robin();
      apply_reset();
      wrap_enable = '1;
      for (int i = 0; i < 18; i++) begin
         cycle();
         checks++;
         if (got !== pack(i < 16, i % N)) $display("FAIL rr_seq[%0d]: got %b want %b", i, got, pack(i < 16, i % N));
         else passes++;
         checks++;
         if (got !== pack(m_valid, m_id)) $display("FAIL rr_model[%0d]: got %b want %b", i, got, pack(m_valid, m_id));
         else passes++;
      end
   endtask

   task automatic test_single_wrap();
      int grants = 0;
      apply_reset();
      wrap_enable = 4'b0100;
      for (int i = 0; i < 6; i++) begin
         cycle();
         checks++;
         if (got !== pack(i < 4, 2)) $display("FAIL single_seq[%0d]: got %b want %b", i, got, pack(i < 4, 2));
         else passes++;
      end
      iq_dequeue[2] = 1'b1;
      cycle();
      checks++;
      if (got !== pack(0, 0)) $display("FAIL single_dequeue_edge: got %b want %b", got, pack(0, 0));
      else passes++;
      repeat (4) begin
         cycle();
         if (select_valid) grants++;
         checks++;
         if (got !== pack(m_valid, m_id)) $display("FAIL single_model: got %b want %b", got, pack(m_valid, m_id));
         else passes++;
      end
      checks++;
      if (grants !== 1) $display("FAIL single_extra_grants: got %0d want 1", grants);
      else passes++;
   endtask

   // Runs with ready=1 until idle, adding each grant to cnt, then checks every wrap reached DEPTH.
   task automatic drain_and_count(input string name, input int cnt_in [N]);
      int cnt [N];
      cnt = cnt_in;
      ifetch_ready = 1'b1;
      for (int i = 0; i < 24; i++) begin
         cycle();
         if (select_valid) cnt[selected_wrap_id]++;
         checks++;
         if (got !== pack(m_valid, m_id)) $display("FAIL %s_model[%0d]: got %b want %b", name, i, got, pack(m_valid, m_id));
         else passes++;
      end
      for (int w = 0; w < N; w++) begin
         checks++;
         if (cnt[w] !== DEPTH) $display("FAIL %s_grants_w%0d: got %0d want %0d", name, w, cnt[w], DEPTH);
         else passes++;
      end
   endtask

   task automatic test_stall();
      apply_reset();
      wrap_enable = '1;
      cycle();
      cycle();
      ifetch_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         checks++;
         if (got !== pack(1, 1)) $display("FAIL stall_hold[%0d]: got %b want %b", i, got, pack(1, 1));
         else passes++;
      end
      ifetch_ready = 1'b1;
      cycle();
      checks++;
      if (got !== pack(1, 2)) $display("FAIL stall_resume: got %b want %b", got, pack(1, 2));
      else passes++;
      drain_and_count("stall", '{1, 1, 1, 0});
   endtask

   task automatic test_sleep();
      int exp_ids [11] = '{0, 1, 2, 3, 1, 2, 3, 0, 1, 2, 0};
      apply_reset();
      wrap_enable = '1;
      for (int e = 1; e <= 11; e++) begin
         if (e == 2) begin icache_miss_valid = 1'b1; icache_miss_wrap_id = 2'd0; end
         if (e == 5) begin icache_fill_valid = 1'b1; icache_fill_wrap_id = 2'd0; end
         if (e == 9) begin
            icache_miss_valid = 1'b1; icache_miss_wrap_id = 2'd3;
            icache_fill_valid = 1'b1; icache_fill_wrap_id = 2'd3;
         end
         cycle();
         checks++;
         if (got !== pack(1, exp_ids[e-1])) $display("FAIL sleep_seq[%0d]: got %b want %b", e, got, pack(1, exp_ids[e-1]));
         else passes++;
      end
   endtask

   task automatic test_cancel();
      // Cancel by miss on the held wrap.
      apply_reset();
      wrap_enable = '1;
      cycle();
      cycle();
      ifetch_ready = 1'b0;
      cycle();
      checks++;
      if (got !== pack(1, 1)) $display("FAIL cancel_held: got %b want %b", got, pack(1, 1));
      else passes++;
      icache_miss_valid = 1'b1; icache_miss_wrap_id = 2'd1;
      cycle();
      checks++;
      if (got !== pack(0, 0)) $display("FAIL cancel_miss: got %b want %b", got, pack(0, 0));
      else passes++;
      ifetch_ready = 1'b1;
      icache_fill_valid = 1'b1; icache_fill_wrap_id = 2'd1;
      cycle();
      checks++;
      if (got !== pack(1, 2)) $display("FAIL cancel_miss_resume: got %b want %b", got, pack(1, 2));
      else passes++;
      drain_and_count("cancel_miss", '{1, 0, 1, 0});

      // Cancel by disabling the held wrap; its credit must be retained.
      apply_reset();
      wrap_enable = '1;
      cycle();
      cycle();
      ifetch_ready = 1'b0;
      cycle();
      wrap_enable = 4'b1101;
      cycle();
      checks++;
      if (got !== pack(0, 0)) $display("FAIL cancel_disable: got %b want %b", got, pack(0, 0));
      else passes++;
      ifetch_ready = 1'b1;
      cycle();
      checks++;
      if (got !== pack(1, 2)) $display("FAIL cancel_disable_resume: got %b want %b", got, pack(1, 2));
      else passes++;
      wrap_enable = '1;
      drain_and_count("cancel_dis", '{1, 0, 1, 0});
   endtask

   task automatic test_same_cycle();
      apply_reset();
      wrap_enable = 4'b0001;
      repeat (3) cycle();
      iq_dequeue[0] = 1'b1;
      cycle();
      checks++;
      if (got !== pack(1, 0)) $display("FAIL same_cycle_grant: got %b want %b", got, pack(1, 0));
      else passes++;
      cycle();
      checks++;
      if (got !== pack(1, 0)) $display("FAIL same_cycle_last_credit: got %b want %b", got, pack(1, 0));
      else passes++;
      cycle();
      checks++;
      if (got !== pack(0, 0)) $display("FAIL same_cycle_exhausted: got %b want %b", got, pack(0, 0));
      else passes++;
   endtask

   task automatic test_random();
      apply_reset();
      wrap_enable = '1;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 9) == 0) wrap_enable = N'($urandom_range(0, (1 << N) - 1));
         ifetch_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 9) == 0) begin
            icache_miss_valid = 1'b1; icache_miss_wrap_id = ID_W'($urandom_range(0, N - 1));
         end
         if ($urandom_range(0, 5) == 0) begin
            icache_fill_valid = 1'b1; icache_fill_wrap_id = ID_W'($urandom_range(0, N - 1));
         end
         for (int w = 0; w < N; w++) begin
            if (m_credit[w] < DEPTH && $urandom_range(0, 2) == 0) iq_dequeue[w] = 1'b1;
         end
         cycle();
         checks++;
         if (got !== pack(m_valid, m_id)) $display("FAIL random_model[%0d]: got %b want %b", i, got, pack(m_valid, m_id));
         else passes++;
      end
   endtask

   task automatic test_mid_reset();
      apply_reset();
      wrap_enable = '1;
      repeat (5) cycle();
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if (got !== pack(0, 0)) $display("FAIL mid_reset_async: got %b want %b", got, pack(0, 0));
      else passes++;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      wrap_enable = 4'b1000;
      for (int i = 0; i < 6; i++) begin
         cycle();
         checks++;
         if (got !== pack(i < 4, 3)) $display("FAIL mid_reset_credit[%0d]: got %b want %b", i, got, pack(i < 4, 3));
         else passes++;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d passed=%0d", checks, passes);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_round_robin();
      test_single_wrap();
      test_stall();
      test_sleep();
      test_cancel();
      test_same_cycle();
      test_random();
      test_mid_reset();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
